// File: rtl/geo_cmd_pkg.sv
// Shared constants for the geometry-processor command transmitter:
// command width, host status bit positions and drop-counter ceiling.
package geo_cmd_pkg;

  localparam int CMD_W = 16;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/geo_cmd_fifo.sv
// Synchronous show-ahead FIFO: o_head always presents the oldest word.
// A push into a full FIFO is accepted when a pop happens in the same clock.
module geo_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Flush wins over both sides; a pop frees the slot a full-FIFO push needs.
  assign w_do_pop  = i_pop & !o_empty & !i_flush;
  assign w_do_push = i_push & !i_flush & (!o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/geo_cmd_transmitter.sv
// Host-side command transmitter: assembles Z80 byte writes into 16-bit words,
// queues them and strobes them out paced by fifo_cmd_busy and a minimum gap.
module geo_cmd_transmitter
  import geo_cmd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MIN_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_wr_ena,
  input  logic             host_wr_hi,
  input  logic [7:0]       host_wr_data,
  input  logic             host_flush,
  input  logic             host_status_rst,
  input  logic             fifo_cmd_busy,
  output logic             fifo_cmd_ready,
  output logic [CMD_W-1:0] fifo_cmd_out,
  output logic [7:0]       host_status,
  output logic [7:0]       host_drop_cnt
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int GAP_W = $clog2(MIN_GAP + 2);

  logic [7:0]       r_lo;
  logic             r_ready;
  logic [CMD_W-1:0] r_out;
  logic [GAP_W-1:0] r_gap;
  logic             r_full_q;
  logic             r_empty_q;
  logic             r_busy_q;
  logic             r_ovf;
  logic [7:0]       r_drop_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [CMD_W-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

  assign w_push = host_wr_ena & host_wr_hi;
  assign w_pop  = !w_empty & !fifo_cmd_busy & (r_gap == '0) & !host_flush;
  assign w_drop = w_push & !host_flush & w_full & !w_pop;

  geo_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data ({host_wr_data, r_lo}),
    .i_pop       (w_pop),
    .i_flush     (host_flush),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo    <= '0;
      r_ready <= 1'b0;
      r_out   <= '0;
      r_gap   <= '0;
    end else begin
      if (host_wr_ena && !host_wr_hi) r_lo <= host_wr_data;
      r_ready <= w_pop;
      if (w_pop) r_out <= w_head;
      if (host_flush)          r_gap <= '0;
      else if (w_pop)          r_gap <= GAP_W'(MIN_GAP);
      else if (r_gap != '0)    r_gap <= r_gap - 1'b1;
    end
  end

  // A drop in the same clock as a status clear counts as the first new drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (host_status_rst)                 r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (host_status_rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
      r_busy_q  <= 1'b0;
    end else begin
      r_full_q  <= (w_count == CW'(DEPTH));
      r_empty_q <= w_empty;
      r_busy_q  <= fifo_cmd_busy;
    end
  end

  always_comb begin
    host_status           = '0;
    host_status[ST_FULL]  = r_full_q;
    host_status[ST_EMPTY] = r_empty_q;
    host_status[ST_BUSY]  = r_busy_q;
    host_status[ST_OVF]   = r_ovf;
  end

  assign fifo_cmd_ready = r_ready;
  assign fifo_cmd_out   = r_out;
  assign host_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_geo_cmd_transmitter.sv
// Bench for geo_cmd_transmitter: a DEPTH=16/MIN_GAP=0 instance for assembly,
// back-pressure, overflow, flush and reset, plus a MIN_GAP=3 instance for pacing.
module tb_geo_cmd_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        host_wr_ena = 1'b0;
  logic        host_wr_hi = 1'b0;
  logic [7:0]  host_wr_data = 8'h00;
  logic        host_flush = 1'b0;
  logic        host_status_rst = 1'b0;
  logic        fifo_cmd_busy = 1'b0;
  logic        fifo_cmd_ready;
  logic [15:0] fifo_cmd_out;
  logic [7:0]  host_status;
  logic [7:0]  host_drop_cnt;

  logic        g_wr_ena = 1'b0;
  logic        g_wr_hi = 1'b0;
  logic [7:0]  g_wr_data = 8'h00;
  logic        g_busy = 1'b0;
  logic        g_ready;
  logic [15:0] g_out;
  logic [7:0]  g_status;
  logic [7:0]  g_drop;

  geo_cmd_transmitter #(.DEPTH(16), .MIN_GAP(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .host_wr_ena     (host_wr_ena),
    .host_wr_hi      (host_wr_hi),
    .host_wr_data    (host_wr_data),
    .host_flush      (host_flush),
    .host_status_rst (host_status_rst),
    .fifo_cmd_busy   (fifo_cmd_busy),
    .fifo_cmd_ready  (fifo_cmd_ready),
    .fifo_cmd_out    (fifo_cmd_out),
    .host_status     (host_status),
    .host_drop_cnt   (host_drop_cnt)
  );

  geo_cmd_transmitter #(.DEPTH(16), .MIN_GAP(3)) dut_gap (
    .clk             (clk),
    .reset           (reset),
    .host_wr_ena     (g_wr_ena),
    .host_wr_hi      (g_wr_hi),
    .host_wr_data    (g_wr_data),
    .host_flush      (1'b0),
    .host_status_rst (1'b0),
    .fifo_cmd_busy   (g_busy),
    .fifo_cmd_ready  (g_ready),
    .fifo_cmd_out    (g_out),
    .host_status     (g_status),
    .host_drop_cnt   (g_drop)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  logic [15:0] exp_q[$];
  logic [15:0] g_exp_q[$];
  int          strobe_t[$];
  int          g_strobe_t[$];
  logic [15:0] mon_exp;
  logic [15:0] g_mon_exp;

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_cmd_ready) begin
      strobe_t.push_back(cycle);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got %h at cycle %0d, required no strobe", fifo_cmd_out, cycle);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_cmd_out !== mon_exp)
          $display("FAIL cmd_word: got %h, required %h", fifo_cmd_out, mon_exp);
        else
          n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (g_ready) begin
      g_strobe_t.push_back(cycle);
      n_checks++;
      if (g_exp_q.size() == 0) begin
        $display("FAIL gap_unexpected_strobe: got %h at cycle %0d, required no strobe", g_out, cycle);
      end else begin
        g_mon_exp = g_exp_q.pop_front();
        if (g_out !== g_mon_exp)
          $display("FAIL gap_cmd_word: got %h, required %h", g_out, g_mon_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_byte(input logic hi, input logic [7:0] d);
    host_wr_ena  = 1'b1;
    host_wr_hi   = hi;
    host_wr_data = d;
    tick();
    host_wr_ena  = 1'b0;
    host_wr_hi   = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w, input bit accept);
    wr_byte(1'b0, w[7:0]);
    wr_byte(1'b1, w[15:8]);
    if (accept) exp_q.push_back(w);
  endtask

  task automatic g_push_word(input logic [15:0] w);
    g_wr_ena = 1'b1; g_wr_hi = 1'b0; g_wr_data = w[7:0];
    tick();
    g_wr_hi = 1'b1; g_wr_data = w[15:8];
    tick();
    g_wr_ena = 1'b0; g_wr_hi = 1'b0;
    g_exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s_drain: %0d words still pending after %0d clocks, required 0", name, exp_q.size(), budget);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tick();
    n_checks++;
    if (fifo_cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", fifo_cmd_ready); else n_pass++;
    n_checks++;
    if (fifo_cmd_out !== 16'h0000) $display("FAIL reset_out: got %h, required 0000", fifo_cmd_out); else n_pass++;
    n_checks++;
    if (host_status !== 8'h02) $display("FAIL reset_status: got %h, required 02", host_status); else n_pass++;
    n_checks++;
    if (host_drop_cnt !== 8'h00) $display("FAIL reset_drop: got %0d, required 0", host_drop_cnt); else n_pass++;
  endtask

  task automatic test_byte_assembly();
    int hi_edge;
    strobe_t.delete();
    wr_byte(1'b0, 8'h34);
    wr_byte(1'b1, 8'h12);
    hi_edge = cycle;
    exp_q.push_back(16'h1234);
    idle(5);
    n_checks++;
    if (strobe_t.size() != 1) $display("FAIL assembly_strobe_count: got %0d, required 1", strobe_t.size()); else n_pass++;
    n_checks++;
    if (strobe_t.size() < 1 || strobe_t[0] != hi_edge + 1)
      $display("FAIL assembly_latency: strobe at edge %0d, required edge %0d", (strobe_t.size() > 0) ? strobe_t[0] : -1, hi_edge + 1);
    else n_pass++;
    wr_byte(1'b1, 8'hAB);
    exp_q.push_back(16'hAB34);
    wait_drain("assembly", 20);
    idle(3);
  endtask

  task automatic test_back_pressure();
    int t_rel;
    fifo_cmd_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'h5000 + 16'(i * 16'h0111), 1'b1);
    strobe_t.delete();
    idle(4);
    n_checks++;
    if (strobe_t.size() != 0) $display("FAIL busy_hold: got %0d strobes, required 0", strobe_t.size()); else n_pass++;
    fifo_cmd_busy = 1'b0;
    t_rel = cycle;
    wait_drain("back_pressure", 30);
    idle(2);
    n_checks++;
    if (strobe_t.size() != 5) $display("FAIL release_count: got %0d strobes, required 5", strobe_t.size()); else n_pass++;
    n_checks++;
    if (strobe_t.size() != 5 || strobe_t[0] != t_rel + 1 || strobe_t[4] != t_rel + 5)
      $display("FAIL back_to_back: first/last strobe edges %0d/%0d, required %0d/%0d",
               (strobe_t.size() > 0) ? strobe_t[0] : -1, (strobe_t.size() > 4) ? strobe_t[4] : -1, t_rel + 1, t_rel + 5);
    else n_pass++;

    fifo_cmd_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'h6000 + 16'($urandom_range(0, 4095)), 1'b1);
    strobe_t.delete();
    fifo_cmd_busy = 1'b0;
    idle(3);
    fifo_cmd_busy = 1'b1;
    idle(6);
    n_checks++;
    if (strobe_t.size() != 3) $display("FAIL busy_in_flight: got %0d strobes, required 3", strobe_t.size()); else n_pass++;
    fifo_cmd_busy = 1'b0;
    wait_drain("busy_resume", 30);
    idle(2);
    n_checks++;
    if (strobe_t.size() != 5) $display("FAIL busy_resume_count: got %0d strobes, required 5", strobe_t.size()); else n_pass++;
  endtask

  task automatic test_overflow();
    fifo_cmd_busy = 1'b1;
    for (int i = 0; i < 18; i++) push_word({8'hC0, 8'(i)}, i < 16);
    idle(2);
    n_checks++;
    if (host_status !== 8'h0D) $display("FAIL overflow_status: got %h, required 0d", host_status); else n_pass++;
    n_checks++;
    if (host_drop_cnt !== 8'd2) $display("FAIL overflow_drop: got %0d, required 2", host_drop_cnt); else n_pass++;
    fifo_cmd_busy = 1'b0;
    wait_drain("overflow", 60);
    host_status_rst = 1'b1;
    tick();
    host_status_rst = 1'b0;
    idle(2);
    n_checks++;
    if (host_status !== 8'h02) $display("FAIL status_rst_status: got %h, required 02", host_status); else n_pass++;
    n_checks++;
    if (host_drop_cnt !== 8'd0) $display("FAIL status_rst_drop: got %0d, required 0", host_drop_cnt); else n_pass++;
  endtask

  task automatic test_saturation();
    fifo_cmd_busy = 1'b1;
    wr_byte(1'b0, 8'h77);
    for (int i = 0; i < 16; i++) begin
      wr_byte(1'b1, 8'(i));
      exp_q.push_back({8'(i), 8'h77});
    end
    for (int i = 0; i < 300; i++) wr_byte(1'b1, 8'($urandom_range(0, 255)));
    idle(2);
    n_checks++;
    if (host_drop_cnt !== 8'd255) $display("FAIL drop_saturate: got %0d, required 255", host_drop_cnt); else n_pass++;
    host_status_rst = 1'b1;
    wr_byte(1'b1, 8'hEE);
    host_status_rst = 1'b0;
    n_checks++;
    if (host_drop_cnt !== 8'd1) $display("FAIL drop_vs_rst: got %0d, required 1", host_drop_cnt); else n_pass++;
    n_checks++;
    if (host_status[3] !== 1'b1) $display("FAIL ovf_vs_rst: got %b, required 1", host_status[3]); else n_pass++;
    host_status_rst = 1'b1;
    tick();
    host_status_rst = 1'b0;
    fifo_cmd_busy = 1'b0;
    wait_drain("saturation", 60);
    idle(2);
  endtask

  task automatic test_pacing();
    g_busy = 1'b1;
    for (int i = 0; i < 4; i++) g_push_word(16'h9000 + 16'($urandom_range(0, 4095)));
    g_strobe_t.delete();
    g_busy = 1'b0;
    for (int n = 0; n < 60 && g_exp_q.size() != 0; n++) tick();
    idle(6);
    n_checks++;
    if (g_strobe_t.size() != 4) $display("FAIL gap_count: got %0d strobes, required 4", g_strobe_t.size()); else n_pass++;
    n_checks++;
    if (g_strobe_t.size() != 4 || g_strobe_t[1] - g_strobe_t[0] != 4 ||
        g_strobe_t[2] - g_strobe_t[1] != 4 || g_strobe_t[3] - g_strobe_t[2] != 4)
      $display("FAIL gap_spacing: strobe edge count %0d with first/last %0d/%0d, required spacing 4",
               g_strobe_t.size(), (g_strobe_t.size() > 0) ? g_strobe_t[0] : -1,
               (g_strobe_t.size() > 3) ? g_strobe_t[3] : -1);
    else n_pass++;
    n_checks++;
    if (g_status !== 8'h02 || g_drop !== 8'd0)
      $display("FAIL gap_status: got status %h drop %0d, required 02 and 0", g_status, g_drop);
    else n_pass++;
  endtask

  task automatic test_flush();
    fifo_cmd_busy = 1'b1;
    for (int i = 0; i < 10; i++) push_word({8'hD0, 8'(i)}, 1'b1);
    host_flush = 1'b1;
    wr_byte(1'b1, 8'h99);
    host_flush = 1'b0;
    exp_q.delete();
    strobe_t.delete();
    fifo_cmd_busy = 1'b0;
    idle(5);
    n_checks++;
    if (strobe_t.size() != 0) $display("FAIL flush_strobes: got %0d, required 0", strobe_t.size()); else n_pass++;
    n_checks++;
    if (host_status !== 8'h02) $display("FAIL flush_status: got %h, required 02", host_status); else n_pass++;
    wr_byte(1'b1, 8'h3C);
    exp_q.push_back(16'h3C09);
    wait_drain("flush_lo_kept", 20);
    idle(2);
  endtask

  task automatic test_reset_mid_drain();
    fifo_cmd_busy = 1'b1;
    for (int i = 0; i < 10; i++) push_word({8'hE0, 8'(i + 1)}, 1'b1);
    fifo_cmd_busy = 1'b0;
    idle(3);
    reset = 1'b1;
    tick();
    exp_q.delete();
    strobe_t.delete();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (fifo_cmd_ready !== 1'b0 || fifo_cmd_out !== 16'h0000)
      $display("FAIL mid_reset_outputs: got ready %b out %h, required 0 and 0000", fifo_cmd_ready, fifo_cmd_out);
    else n_pass++;
    n_checks++;
    if (host_status !== 8'h02 || host_drop_cnt !== 8'd0)
      $display("FAIL mid_reset_status: got %h drop %0d, required 02 and 0", host_status, host_drop_cnt);
    else n_pass++;
    idle(3);
    n_checks++;
    if (strobe_t.size() != 0) $display("FAIL mid_reset_strobes: got %0d, required 0", strobe_t.size()); else n_pass++;
    wr_byte(1'b1, 8'h5A);
    exp_q.push_back(16'h5A00);
    wait_drain("post_reset", 20);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_byte_assembly();
    test_back_pressure();
    test_overflow();
    test_saturation();
    test_pacing();
    test_flush();
    test_reset_mid_drain();
    n_checks++;
    if (exp_q.size() != 0 || g_exp_q.size() != 0)
      $display("FAIL leftover_words: got %0d/%0d pending, required 0/0", exp_q.size(), g_exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
